pipe_id_hazard: RTL and testbench

PIPE_ID_HAZARD -- requirements
Module: pipe_id_hazard

---
 rtl/pipe_pkg.sv | 30 +++
 rtl/pipe_fwd_sel.sv | 62 ++++++
 rtl/pipe_id_hazard.sv | 150 +++++++++++++++
 tb/tb_pipe_id_hazard.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// ---------------------------------------------------------------------------
// pipe_pkg
// Shared definitions for the ID-stage hazard / forwarding slice:
//   - branch-type encoding carried on id_branch
//   - forward-select encoding used by pipe_fwd_sel
//   - default datapath and register-number widths
// No ports (package).
// ---------------------------------------------------------------------------
package pipe_pkg;

    localparam int DEF_XLEN  = 32;
    localparam int DEF_RADDR = 5;

    // Encoding of id_branch; the reserved code behaves as "no branch".
    typedef enum logic [1:0] {
        BR_NONE = 2'd0,
        BR_BEQ  = 2'd1,
        BR_BNE  = 2'd2,
        BR_RSVD = 2'd3
    } br_type_e;

    // Where a source operand is taken from.
    typedef enum logic [1:0] {
        FWD_REG     = 2'd0,
        FWD_EX_ALU  = 2'd1,
        FWD_MEM_ALU = 2'd2,
        FWD_MEM_MO  = 2'd3
    } fwd_sel_e;

endpackage

// File: rtl/pipe_fwd_sel.sv
// ---------------------------------------------------------------------------
// pipe_fwd_sel
// Forwarding mux for one ID-stage source operand. Picks the youngest valid
// producer of the source register: an EX ALU result first, then a MEM load
// result or MEM ALU result, otherwise the register-file read data.
// A load still in EX cannot be forwarded (the hazard logic stalls instead).
// Ports:
//   src        in  RADDR  source register number
//   reg_data   in  XLEN   register-file read data
//   ex_wreg, ex_m2reg, ex_rn, ex_alu          EX-stage producer
//   mem_wreg, mem_m2reg, mem_rn, mem_alu, mem_mo  MEM-stage producer
//   fwd        out XLEN   forwarded operand value
// ---------------------------------------------------------------------------
module pipe_fwd_sel
    import pipe_pkg::*;
#(
    parameter int XLEN  = DEF_XLEN,
    parameter int RADDR = DEF_RADDR
) (
    input  logic [RADDR-1:0] src,
    input  logic [XLEN-1:0]  reg_data,
    input  logic             ex_wreg,
    input  logic             ex_m2reg,
    input  logic [RADDR-1:0] ex_rn,
    input  logic [XLEN-1:0]  ex_alu,
    input  logic             mem_wreg,
    input  logic             mem_m2reg,
    input  logic [RADDR-1:0] mem_rn,
    input  logic [XLEN-1:0]  mem_alu,
    input  logic [XLEN-1:0]  mem_mo,
    output logic [XLEN-1:0]  fwd
);

    fwd_sel_e sel;
    logic     ex_hit;
    logic     mem_hit;

    // Register 0 is hard-wired zero, so it never matches a producer.
    assign ex_hit  = ex_wreg && !ex_m2reg && (ex_rn == src) && (src != '0);
    assign mem_hit = mem_wreg && (mem_rn == src) && (src != '0);

    always_comb begin
        sel = FWD_REG;
        if (ex_hit)
            sel = FWD_EX_ALU;
        else if (mem_hit && mem_m2reg)
            sel = FWD_MEM_MO;
        else if (mem_hit)
            sel = FWD_MEM_ALU;
    end

    always_comb begin
        fwd = reg_data;
        case (sel)
            FWD_EX_ALU:  fwd = ex_alu;
            FWD_MEM_ALU: fwd = mem_alu;
            FWD_MEM_MO:  fwd = mem_mo;
            default:     fwd = reg_data;
        endcase
    end

endmodule

// File: rtl/pipe_id_hazard.sv
// ---------------------------------------------------------------------------
// pipe_id_hazard
// ID-stage hazard unit, operand forwarding, branch resolution and the ID/EX
// pipeline register for a classic five-stage pipeline.
// Configuration macro: PIPE_ID_BRANCH_FLUSH_EN
//   defined     -> flush follows pcsel (no branch delay slot)
//   not defined -> flush is 0 (delay slot: the IF instruction executes)
// Ports:
//   clock, reset                 clock, synchronous active-high reset
//   id_*                         decoded instruction in ID
//   ex_*                         EX-stage producer (wreg, m2reg, rn, alu)
//   mem_*                        MEM-stage producer (wreg, m2reg, rn, alu, mo)
//   wpcir                        1 = PC and IF/ID advance, 0 = stall
//   pcsel, bpc                   branch taken / branch target
//   flush                        squash the instruction in IF/ID
//   e_*                          registered ID/EX outputs
//   stall_cnt                    saturating stall-cycle counter
// ---------------------------------------------------------------------------
module pipe_id_hazard
    import pipe_pkg::*;
#(
    parameter int XLEN  = DEF_XLEN,
    parameter int RADDR = DEF_RADDR,
    parameter int CNTW  = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             id_valid,
    input  logic [RADDR-1:0] id_rs,
    input  logic [RADDR-1:0] id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic [XLEN-1:0]  id_qa,
    input  logic [XLEN-1:0]  id_qb,
    input  logic             id_wreg,
    input  logic             id_m2reg,
    input  logic             id_wmem,
    input  logic             id_aluimm,
    input  logic [RADDR-1:0] id_rn,
    input  logic [XLEN-1:0]  id_imm,
    input  logic [XLEN-1:0]  id_bpc,
    input  logic [1:0]       id_branch,
    input  logic             ex_wreg,
    input  logic             ex_m2reg,
    input  logic [RADDR-1:0] ex_rn,
    input  logic [XLEN-1:0]  ex_alu,
    input  logic             mem_wreg,
    input  logic             mem_m2reg,
    input  logic [RADDR-1:0] mem_rn,
    input  logic [XLEN-1:0]  mem_alu,
    input  logic [XLEN-1:0]  mem_mo,
    output logic             wpcir,
    output logic             pcsel,
    output logic [XLEN-1:0]  bpc,
    output logic             flush,
    output logic             e_valid,
    output logic             e_wreg,
    output logic             e_m2reg,
    output logic             e_wmem,
    output logic             e_aluimm,
    output logic [RADDR-1:0] e_rn,
    output logic [XLEN-1:0]  e_a,
    output logic [XLEN-1:0]  e_b,
    output logic [XLEN-1:0]  e_imm,
    output logic [CNTW-1:0]  stall_cnt
);

    logic [XLEN-1:0] fwd_a;
    logic [XLEN-1:0] fwd_b;
    logic            is_beq;
    logic            is_bne;
    logic            ex_hit_rs;
    logic            ex_hit_rt;
    logic            load_use;
    logic            branch_stall;
    logic            stall;
    logic            taken;

    pipe_fwd_sel #(.XLEN(XLEN), .RADDR(RADDR)) u_fwd_a (
        .src(id_rs), .reg_data(id_qa),
        .ex_wreg(ex_wreg), .ex_m2reg(ex_m2reg), .ex_rn(ex_rn), .ex_alu(ex_alu),
        .mem_wreg(mem_wreg), .mem_m2reg(mem_m2reg), .mem_rn(mem_rn),
        .mem_alu(mem_alu), .mem_mo(mem_mo), .fwd(fwd_a)
    );

    pipe_fwd_sel #(.XLEN(XLEN), .RADDR(RADDR)) u_fwd_b (
        .src(id_rt), .reg_data(id_qb),
        .ex_wreg(ex_wreg), .ex_m2reg(ex_m2reg), .ex_rn(ex_rn), .ex_alu(ex_alu),
        .mem_wreg(mem_wreg), .mem_m2reg(mem_m2reg), .mem_rn(mem_rn),
        .mem_alu(mem_alu), .mem_mo(mem_mo), .fwd(fwd_b)
    );

    assign is_beq = (id_branch == BR_BEQ);
    assign is_bne = (id_branch == BR_BNE);

    // EX writes one of our source registers (r0 excluded).
    assign ex_hit_rs = ex_wreg && (ex_rn != '0) && (ex_rn == id_rs);
    assign ex_hit_rt = ex_wreg && (ex_rn != '0) && (ex_rn == id_rt);

    // A load in EX has no data yet; a branch compares in ID so even an EX
    // ALU result arrives too late for it.
    assign load_use     = ex_m2reg && ((id_use_rs && ex_hit_rs) || (id_use_rt && ex_hit_rt));
    assign branch_stall = (is_beq || is_bne) && (ex_hit_rs || ex_hit_rt);
    assign stall        = id_valid && (load_use || branch_stall);
    assign wpcir        = !stall;

    assign taken = (is_beq && (fwd_a == fwd_b)) || (is_bne && (fwd_a != fwd_b));
    assign pcsel = id_valid && !stall && taken;
    assign bpc   = id_bpc;

`ifdef PIPE_ID_BRANCH_FLUSH_EN
    assign flush = pcsel;
`else
    assign flush = 1'b0;
`endif

    // ID/EX register: a stall or an empty ID slot loads an all-zero bubble.
    always_ff @(posedge clock) begin
        if (reset || stall || !id_valid) begin
            e_valid  <= 1'b0;
            e_wreg   <= 1'b0;
            e_m2reg  <= 1'b0;
            e_wmem   <= 1'b0;
            e_aluimm <= 1'b0;
            e_rn     <= '0;
            e_a      <= '0;
            e_b      <= '0;
            e_imm    <= '0;
        end else begin
            e_valid  <= 1'b1;
            e_wreg   <= id_wreg;
            e_m2reg  <= id_m2reg;
            e_wmem   <= id_wmem;
            e_aluimm <= id_aluimm;
            e_rn     <= id_rn;
            e_a      <= fwd_a;
            e_b      <= id_aluimm ? id_imm : fwd_b;
            e_imm    <= id_imm;
        end
    end

    // Stall-cycle counter, saturating at all-ones.
    always_ff @(posedge clock) begin
        if (reset)
            stall_cnt <= '0;
        else if (stall && (stall_cnt != '1))
            stall_cnt <= stall_cnt + CNTW'(1);
    end

endmodule

// File: tb/tb_pipe_id_hazard.sv
// ---------------------------------------------------------------------------
// tb_pipe_id_hazard
// Directed self-checking bench for pipe_id_hazard (CNTW reduced to 4 so the
// counter saturation case stays short).
// ---------------------------------------------------------------------------
module tb_pipe_id_hazard;

    localparam int XLEN  = 32;
    localparam int RADDR = 5;
    localparam int CNTW  = 4;

    logic             clock = 1'b0;
    logic             reset;
    logic             id_valid, id_use_rs, id_use_rt;
    logic [RADDR-1:0] id_rs, id_rt, id_rn;
    logic [XLEN-1:0]  id_qa, id_qb, id_imm, id_bpc;
    logic             id_wreg, id_m2reg, id_wmem, id_aluimm;
    logic [1:0]       id_branch;
    logic             ex_wreg, ex_m2reg;
    logic [RADDR-1:0] ex_rn;
    logic [XLEN-1:0]  ex_alu;
    logic             mem_wreg, mem_m2reg;
    logic [RADDR-1:0] mem_rn;
    logic [XLEN-1:0]  mem_alu, mem_mo;
    logic             wpcir, pcsel, flush;
    logic [XLEN-1:0]  bpc;
    logic             e_valid, e_wreg, e_m2reg, e_wmem, e_aluimm;
    logic [RADDR-1:0] e_rn;
    logic [XLEN-1:0]  e_a, e_b, e_imm;
    logic [CNTW-1:0]  stall_cnt;

    int checks = 0;
    int errors = 0;

`ifdef PIPE_ID_BRANCH_FLUSH_EN
    localparam logic FLUSH_ON_TAKEN = 1'b1;
`else
    localparam logic FLUSH_ON_TAKEN = 1'b0;
`endif

    pipe_id_hazard #(.XLEN(XLEN), .RADDR(RADDR), .CNTW(CNTW)) dut (
        .clock(clock), .reset(reset),
        .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
        .id_qa(id_qa), .id_qb(id_qb),
        .id_wreg(id_wreg), .id_m2reg(id_m2reg), .id_wmem(id_wmem), .id_aluimm(id_aluimm),
        .id_rn(id_rn), .id_imm(id_imm), .id_bpc(id_bpc), .id_branch(id_branch),
        .ex_wreg(ex_wreg), .ex_m2reg(ex_m2reg), .ex_rn(ex_rn), .ex_alu(ex_alu),
        .mem_wreg(mem_wreg), .mem_m2reg(mem_m2reg), .mem_rn(mem_rn),
        .mem_alu(mem_alu), .mem_mo(mem_mo),
        .wpcir(wpcir), .pcsel(pcsel), .bpc(bpc), .flush(flush),
        .e_valid(e_valid), .e_wreg(e_wreg), .e_m2reg(e_m2reg), .e_wmem(e_wmem),
        .e_aluimm(e_aluimm), .e_rn(e_rn), .e_a(e_a), .e_b(e_b), .e_imm(e_imm),
        .stall_cnt(stall_cnt)
    );

    always #5 clock = ~clock;

    // Advance one rising edge and sample 1 ns later.
    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    // Let combinational outputs settle after driving inputs.
    task automatic settle;
        #1;
    endtask

    // Idle producers, then present an ALU-type instruction in ID.
    task automatic applyStimulus(input logic valid, input logic [RADDR-1:0] rs,
                                 input logic [RADDR-1:0] rt, input logic [XLEN-1:0] qa,
                                 input logic [XLEN-1:0] qb, input logic [RADDR-1:0] rn,
                                 input logic [1:0] br);
        id_valid  = valid;
        id_rs     = rs;
        id_rt     = rt;
        id_use_rs = 1'b1;
        id_use_rt = 1'b1;
        id_qa     = qa;
        id_qb     = qb;
        id_rn     = rn;
        id_wreg   = (br == 2'd0);
        id_m2reg  = 1'b0;
        id_wmem   = 1'b0;
        id_aluimm = 1'b0;
        id_imm    = '0;
        id_bpc    = '0;
        id_branch = br;
        ex_wreg   = 1'b0;
        ex_m2reg  = 1'b0;
        ex_rn     = '0;
        ex_alu    = '0;
        mem_wreg  = 1'b0;
        mem_m2reg = 1'b0;
        mem_rn    = '0;
        mem_alu   = '0;
        mem_mo    = '0;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    initial begin
        $display("[TB] start");

        // Reset with a load-use hazard present: wpcir is not gated by reset,
        // but registers and the counter must stay cleared.
        reset = 1'b1;
        applyStimulus(1'b1, 5'd3, 5'd1, 32'h5, 32'h7, 5'd4, 2'd0);
        ex_wreg = 1'b1; ex_m2reg = 1'b1; ex_rn = 5'd3;
        settle();
        checkOutput("rst_wpcir", {31'b0, wpcir}, 32'h0);
        tick();
        tick();
        checkOutput("rst_e_valid", {31'b0, e_valid}, 32'h0);
        checkOutput("rst_e_a", e_a, 32'h0);
        checkOutput("rst_stall_cnt", {28'b0, stall_cnt}, 32'h0);
        reset = 1'b0;

        // EX ALU forwarding to rs.
        applyStimulus(1'b1, 5'd3, 5'd1, 32'h5, 32'h7, 5'd4, 2'd0);
        ex_wreg = 1'b1; ex_rn = 5'd3; ex_alu = 32'h9;
        settle();
        checkOutput("exfwd_wpcir", {31'b0, wpcir}, 32'h1);
        tick();
        checkOutput("exfwd_e_a", e_a, 32'h9);
        checkOutput("exfwd_e_b", e_b, 32'h7);
        checkOutput("exfwd_e_valid", {31'b0, e_valid}, 32'h1);
        checkOutput("exfwd_e_rn", {27'b0, e_rn}, 32'h4);

        // MEM ALU forwarding to rt.
        applyStimulus(1'b1, 5'd3, 5'd1, 32'h5, 32'h7, 5'd4, 2'd0);
        mem_wreg = 1'b1; mem_rn = 5'd1; mem_alu = 32'h55; mem_mo = 32'hBAD;
        tick();
        checkOutput("memfwd_e_a", e_a, 32'h5);
        checkOutput("memfwd_e_b", e_b, 32'h55);

        // EX has priority over MEM for the same register.
        ex_wreg = 1'b1; ex_rn = 5'd1; ex_alu = 32'h66;
        tick();
        checkOutput("prio_e_b", e_b, 32'h66);

        // Immediate operand replaces rt data.
        applyStimulus(1'b1, 5'd3, 5'd1, 32'h5, 32'h7, 5'd4, 2'd0);
        id_aluimm = 1'b1; id_imm = 32'hABC;
        tick();
        checkOutput("imm_e_b", e_b, 32'hABC);
        checkOutput("imm_e_imm", e_imm, 32'hABC);
        checkOutput("imm_e_aluimm", {31'b0, e_aluimm}, 32'h1);

        // Load-use: one stall cycle, then MEM load data forwarded.
        applyStimulus(1'b1, 5'd3, 5'd1, 32'h5, 32'h7, 5'd4, 2'd0);
        ex_wreg = 1'b1; ex_m2reg = 1'b1; ex_rn = 5'd3; ex_alu = 32'hDEAD;
        settle();
        checkOutput("lu_wpcir", {31'b0, wpcir}, 32'h0);
        tick();
        checkOutput("lu_bubble_valid", {31'b0, e_valid}, 32'h0);
        checkOutput("lu_bubble_wreg", {31'b0, e_wreg}, 32'h0);
        checkOutput("lu_stall_cnt", {28'b0, stall_cnt}, 32'h1);
        ex_wreg = 1'b0; ex_m2reg = 1'b0; ex_rn = '0;
        mem_wreg = 1'b1; mem_m2reg = 1'b1; mem_rn = 5'd3;
        mem_mo = 32'h1234; mem_alu = 32'hDEAD;
        settle();
        checkOutput("lu2_wpcir", {31'b0, wpcir}, 32'h1);
        tick();
        checkOutput("lu2_e_a", e_a, 32'h1234);
        checkOutput("lu2_stall_cnt", {28'b0, stall_cnt}, 32'h1);

        // Load in EX but sources not actually read: no stall.
        applyStimulus(1'b1, 5'd3, 5'd3, 32'h5, 32'h7, 5'd4, 2'd0);
        id_use_rs = 1'b0; id_use_rt = 1'b0;
        ex_wreg = 1'b1; ex_m2reg = 1'b1; ex_rn = 5'd3;
        settle();
        checkOutput("nouse_wpcir", {31'b0, wpcir}, 32'h1);

        // r0 producer: neither forwarded nor stalling.
        applyStimulus(1'b1, 5'd0, 5'd1, 32'h11, 32'h7, 5'd4, 2'd0);
        ex_wreg = 1'b1; ex_m2reg = 1'b1; ex_rn = 5'd0; ex_alu = 32'h99;
        settle();
        checkOutput("r0_wpcir", {31'b0, wpcir}, 32'h1);
        tick();
        checkOutput("r0_e_a", e_a, 32'h11);

        // beq r2,r0 with r2 in EX: stall, then resolve with MEM forwarding.
        applyStimulus(1'b1, 5'd2, 5'd0, 32'h77, 32'h0, 5'd0, 2'd1);
        id_bpc = 32'h400;
        ex_wreg = 1'b1; ex_rn = 5'd2; ex_alu = 32'h5;
        settle();
        checkOutput("br_stall_wpcir", {31'b0, wpcir}, 32'h0);
        checkOutput("br_stall_pcsel", {31'b0, pcsel}, 32'h0);
        tick();
        checkOutput("br_stall_cnt", {28'b0, stall_cnt}, 32'h2);
        ex_wreg = 1'b0; ex_rn = '0;
        mem_wreg = 1'b1; mem_rn = 5'd2; mem_alu = 32'h0;
        settle();
        checkOutput("br_wpcir", {31'b0, wpcir}, 32'h1);
        checkOutput("br_pcsel", {31'b0, pcsel}, 32'h1);
        checkOutput("br_bpc", bpc, 32'h400);
        checkOutput("br_flush", {31'b0, flush}, {31'b0, FLUSH_ON_TAKEN});
        tick();

        // bne not taken / taken.
        applyStimulus(1'b1, 5'd2, 5'd1, 32'h3, 32'h3, 5'd0, 2'd2);
        settle();
        checkOutput("bne_nt_pcsel", {31'b0, pcsel}, 32'h0);
        checkOutput("bne_nt_flush", {31'b0, flush}, 32'h0);
        id_qb = 32'h4;
        settle();
        checkOutput("bne_t_pcsel", {31'b0, pcsel}, 32'h1);

        // Reserved branch code: no branch stall, never taken.
        applyStimulus(1'b1, 5'd2, 5'd1, 32'h3, 32'h4, 5'd0, 2'd3);
        id_use_rs = 1'b0; id_use_rt = 1'b0;
        ex_wreg = 1'b1; ex_rn = 5'd2;
        settle();
        checkOutput("rsvd_wpcir", {31'b0, wpcir}, 32'h1);
        checkOutput("rsvd_pcsel", {31'b0, pcsel}, 32'h0);

        // Empty ID slot with a would-be hazard: bubble, no stall, no count.
        applyStimulus(1'b0, 5'd3, 5'd1, 32'h5, 32'h7, 5'd4, 2'd0);
        ex_wreg = 1'b1; ex_m2reg = 1'b1; ex_rn = 5'd3;
        settle();
        checkOutput("inv_wpcir", {31'b0, wpcir}, 32'h1);
        tick();
        checkOutput("inv_e_valid", {31'b0, e_valid}, 32'h0);
        checkOutput("inv_stall_cnt", {28'b0, stall_cnt}, 32'h2);

        // Saturation: 2^CNTW+3 stall cycles.
        id_valid = 1'b1;
        for (int i = 0; i < (1 << CNTW) + 3; i++)
            tick();
        checkOutput("sat_stall_cnt", {28'b0, stall_cnt}, 32'hF);
        checkOutput("sat_e_valid", {31'b0, e_valid}, 32'h0);

        // Reset mid-stall clears the counter.
        reset = 1'b1;
        tick();
        checkOutput("midrst_stall_cnt", {28'b0, stall_cnt}, 32'h0);
        checkOutput("midrst_e_valid", {31'b0, e_valid}, 32'h0);
        reset = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
